image_stream_tx: RTL and testbench

IMAGE_STREAM_TX -- requirements
Module: image_stream_tx

---
 rtl/image_stream_tx_pkg.sv | 26 ++
 rtl/image_stream_tx_pattern_gen.sv | 22 ++
 rtl/image_stream_tx.sv | 110 +++++++++++
 tb/tb_image_stream_tx.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/image_stream_tx_pkg.sv
// Shared stream word-type codes, header terminal addresses and the FSM/pattern types
// used by the image stream transmitter.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH         4
`define DTYPE_FRAME_START   4'd1
`define DTYPE_FRAME_END     4'd2
`define DTYPE_HEADER_START  4'd3
`define DTYPE_HEADER        4'd4
`define DTYPE_HEADER_END    4'd5
`define DTYPE_ROW_START     4'd6
`define DTYPE_PIXEL         4'd7
`define DTYPE_ROW_END       4'd8
`endif

`ifndef Image_num_cols
`define Image_num_cols 1
`define Image_num_rows 2
`endif

package image_stream_tx_pkg;
  typedef enum logic [3:0] {
    IDLE, FSTART, HSTART, HDR, HEND, RSTART, PIX, REND, GAP, FEND
  } state_t;

  typedef enum logic [1:0] {PAT_RAMP, PAT_CONST, PAT_CHECK, PAT_FCNT} pat_t;
endpackage

// File: rtl/image_stream_tx_pattern_gen.sv
// Combinational pixel source: value for a given column/row under the frame's pattern.
module pattern_gen
  import image_stream_tx_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int DIM_WIDTH   = 12
) (
  input  logic [1:0]             pattern,
  input  logic [DIM_WIDTH-1:0]   col,
  input  logic [DIM_WIDTH-1:0]   row,
  input  logic [15:0]            frame_cnt,
  output logic [PIXEL_WIDTH-1:0] pixel
);
  always_comb begin
    case (pat_t'(pattern))
      PAT_RAMP:  pixel = PIXEL_WIDTH'(col) + PIXEL_WIDTH'(row);
      PAT_CONST: pixel = '1;
      PAT_CHECK: pixel = (col[0] ^ row[0]) ? '1 : '0;
      default:   pixel = PIXEL_WIDTH'(frame_cnt);
    endcase
  end
endmodule

// File: rtl/image_stream_tx.sv
// Frame word generator: emits frame/header/row/pixel words, one per non-stalled cycle.
// The state always names the word currently presented on the outputs.
module image_stream_tx
  import image_stream_tx_pkg::*;
#(
  parameter int PIXEL_WIDTH = 10,
  parameter int DATA_WIDTH  = 16,
  parameter int DIM_WIDTH   = 12,
  parameter int HEADER_LEN  = 8
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    start,
  input  logic                    stall,
  input  logic [DIM_WIDTH-1:0]    num_cols,
  input  logic [DIM_WIDTH-1:0]    num_rows,
  input  logic [7:0]              row_gap,
  input  logic [1:0]              pattern,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  datao,
  output logic [DATA_WIDTH-1:0]   meta_datao,
  output logic                    busy
);
  localparam logic [5:0]           HDR_LAST = 6'(HEADER_LEN - 1);
  localparam logic [DIM_WIDTH-1:0] DIM_ONE  = DIM_WIDTH'(1);

  state_t               state;
  logic [DIM_WIDTH-1:0] cols_q, rows_q, col_cnt, row_cnt, col_nxt;
  logic [7:0]           gap_q, gap_cnt;
  logic [1:0]           pat_q;
  logic [5:0]           hdr_cnt, hdr_nxt;
  logic [15:0]          frame_cnt;
  logic [PIXEL_WIDTH-1:0] pix_nxt;
  logic [DATA_WIDTH-1:0]  hdr_val;
  logic                 last_row;

  // Look-ahead indices: values for the word about to be presented.
  assign hdr_nxt  = (state == HDR) ? hdr_cnt + 6'd1 : 6'd0;
  assign col_nxt  = (state == PIX) ? col_cnt + DIM_ONE : '0;
  assign last_row = (row_cnt == rows_q - DIM_ONE);

  always_comb begin
    hdr_val = '0;
    if (hdr_nxt == 6'(`Image_num_cols))      hdr_val = DATA_WIDTH'(cols_q);
    else if (hdr_nxt == 6'(`Image_num_rows)) hdr_val = DATA_WIDTH'(rows_q);
    else if (hdr_nxt == HDR_LAST)            hdr_val = DATA_WIDTH'(frame_cnt);
  end

  pattern_gen #(.PIXEL_WIDTH(PIXEL_WIDTH), .DIM_WIDTH(DIM_WIDTH)) u_pat (
    .pattern(pat_q), .col(col_nxt), .row(row_cnt), .frame_cnt(frame_cnt), .pixel(pix_nxt)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state <= IDLE; dvo <= 1'b0; dtypeo <= '0; datao <= '0; meta_datao <= '0; busy <= 1'b0;
      cols_q <= '0; rows_q <= '0; gap_q <= '0; pat_q <= '0;
      col_cnt <= '0; row_cnt <= '0; gap_cnt <= '0; hdr_cnt <= '0; frame_cnt <= '0;
    end else if (stall) begin
      dvo <= 1'b0;
    end else begin
      dvo <= 1'b1;
      case (state)
        IDLE: begin
          dvo <= 1'b0;
          if (start && enable) begin
            cols_q <= num_cols; rows_q <= num_rows; gap_q <= row_gap; pat_q <= pattern;
            col_cnt <= '0; row_cnt <= '0; gap_cnt <= '0; hdr_cnt <= '0;
            state <= FSTART; dvo <= 1'b1; dtypeo <= `DTYPE_FRAME_START; busy <= 1'b1;
          end
        end
        FSTART: begin state <= HSTART; dtypeo <= `DTYPE_HEADER_START; end
        HSTART, HDR: begin
          if (state == HDR && hdr_cnt == HDR_LAST) begin
            state <= HEND; dtypeo <= `DTYPE_HEADER_END;
          end else begin
            state <= HDR; dtypeo <= `DTYPE_HEADER; hdr_cnt <= hdr_nxt; meta_datao <= hdr_val;
          end
        end
        HEND: begin
          if (rows_q == '0) begin state <= FEND; dtypeo <= `DTYPE_FRAME_END; end
          else begin state <= RSTART; dtypeo <= `DTYPE_ROW_START; row_cnt <= '0; end
        end
        RSTART, PIX: begin
          if ((state == RSTART && cols_q == '0) || (state == PIX && col_cnt == cols_q - DIM_ONE)) begin
            state <= REND; dtypeo <= `DTYPE_ROW_END;
          end else begin
            state <= PIX; dtypeo <= `DTYPE_PIXEL; col_cnt <= col_nxt; datao <= pix_nxt;
          end
        end
        REND, GAP: begin
          if (state == REND && gap_q != 8'd0) begin
            state <= GAP; dvo <= 1'b0; gap_cnt <= 8'd1;
          end else if (state == GAP && gap_cnt != gap_q) begin
            dvo <= 1'b0; gap_cnt <= gap_cnt + 8'd1;
          end else if (last_row) begin
            state <= FEND; dtypeo <= `DTYPE_FRAME_END;
          end else begin
            state <= RSTART; dtypeo <= `DTYPE_ROW_START; row_cnt <= row_cnt + DIM_ONE;
          end
        end
        FEND: begin
          state <= IDLE; dvo <= 1'b0; busy <= 1'b0; frame_cnt <= frame_cnt + 16'd1;
        end
        default: begin state <= IDLE; dvo <= 1'b0; busy <= 1'b0; end
      endcase
    end
  end
endmodule

// File: tb/tb_image_stream_tx.sv
// Scoreboarded bench for image_stream_tx: a frame-level model queues expected words,
// a negedge monitor pops and compares every presented word.
`timescale 1ns/1ps
module tb_image_stream_tx;
  import image_stream_tx_pkg::*;
  localparam int PW = 10, DW = 16, DIMW = 12, HL = 8;
  localparam int PMAX = (1 << PW) - 1;

  logic clk = 1'b0, resetb = 1'b0, enable = 1'b0, start = 1'b0, stall = 1'b0;
  logic [DIMW-1:0] num_cols = '0, num_rows = '0;
  logic [7:0] row_gap = '0;
  logic [1:0] pattern = '0;
  logic dvo, busy;
  logic [`DTYPE_WIDTH-1:0] dtypeo;
  logic [PW-1:0] datao;
  logic [DW-1:0] meta_datao;

  always #5 clk = ~clk;

  image_stream_tx #(.PIXEL_WIDTH(PW), .DATA_WIDTH(DW), .DIM_WIDTH(DIMW), .HEADER_LEN(HL)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .start(start), .stall(stall),
    .num_cols(num_cols), .num_rows(num_rows), .row_gap(row_gap), .pattern(pattern),
    .dvo(dvo), .dtypeo(dtypeo), .datao(datao), .meta_datao(meta_datao), .busy(busy)
  );

  typedef struct { int dt; int val; } word_t;
  word_t exp_q[$];
  word_t obs_q[$];
  int tot = 0, bad = 0, cyc = 0;
  int fs_cyc = 0, fe_cyc = 0, fe_to_fs = 0, rs_cnt = 0, fs_total = 0, m_fcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tot++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, want);
    end
  endtask

  function automatic void push_word(int dt, int val);
    word_t w;
    w.dt = dt; w.val = val;
    exp_q.push_back(w);
  endfunction

  // Frame as a flat list of words, built straight from the stream layout rules.
  function automatic void push_frame(int c, int r, int p, int fc);
    int v, px;
    push_word(`DTYPE_FRAME_START, 0);
    push_word(`DTYPE_HEADER_START, 0);
    for (int k = 0; k < HL; k++) begin
      v = 0;
      if (k == `Image_num_cols) v = c;
      else if (k == `Image_num_rows) v = r;
      else if (k == HL - 1) v = fc % 65536;
      push_word(`DTYPE_HEADER, v);
    end
    push_word(`DTYPE_HEADER_END, 0);
    for (int y = 0; y < r; y++) begin
      push_word(`DTYPE_ROW_START, 0);
      for (int x = 0; x < c; x++) begin
        case (p)
          0: px = (x + y) % (PMAX + 1);
          1: px = PMAX;
          2: px = ((x + y) % 2 == 1) ? PMAX : 0;
          default: px = fc % (PMAX + 1);
        endcase
        push_word(`DTYPE_PIXEL, px);
      end
      push_word(`DTYPE_ROW_END, 0);
    end
    push_word(`DTYPE_FRAME_END, 0);
  endfunction

  initial forever begin @(posedge clk); cyc++; end

  initial forever begin
    word_t o, e;
    @(negedge clk);
    if (resetb && dvo) begin
      o.dt = int'(dtypeo);
      o.val = (dtypeo == `DTYPE_PIXEL) ? int'(datao) :
              (dtypeo == `DTYPE_HEADER) ? int'(meta_datao) : 0;
      if (dtypeo == `DTYPE_FRAME_START) begin
        obs_q.delete(); fe_to_fs = cyc - fe_cyc; fs_cyc = cyc; rs_cnt = 0; fs_total++;
      end
      if (dtypeo == `DTYPE_ROW_START) rs_cnt++;
      if (dtypeo == `DTYPE_FRAME_END) fe_cyc = cyc;
      obs_q.push_back(o);
      if (exp_q.size() == 0) chk("unexpected_word", o.dt, 0);
      else begin
        e = exp_q.pop_front();
        chk("word_type", o.dt, e.dt);
        if (e.dt == `DTYPE_PIXEL || e.dt == `DTYPE_HEADER) chk("word_value", o.val, e.val);
      end
    end
  end

  task automatic issue(int c, int r, int g, int p);
    @(posedge clk); #1;
    num_cols = DIMW'(c); num_rows = DIMW'(r); row_gap = 8'(g); pattern = 2'(p);
    stall = 1'b0; enable = 1'b1;
    push_frame(c, r, p, m_fcnt); m_fcnt++;
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("fs_latency_dvo", dvo, 1);
    chk("fs_latency_type", dtypeo, `DTYPE_FRAME_START);
    #1;
  endtask

  task automatic wait_done(int budget, bit rnd);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      if (rnd) stall = ($urandom_range(0, 3) == 0);
      n++;
    end
    stall = 1'b0;
    if (n >= budget) chk("timeout_frame_done", 1, 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic wait_rs(int target);
    int n = 0;
    while (rs_cnt < target && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("timeout_row_start", rs_cnt, target);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got 0 want 1 (simulation did not finish)");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe_before, base, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dvo", dvo, 0); chk("rst_dtypeo", dtypeo, 0); chk("rst_datao", datao, 0);
    chk("rst_meta", meta_datao, 0); chk("rst_busy", busy, 0);
    resetb = 1'b1; enable = 1'b1;

    // 4x3 ramp, no gap, no stall
    issue(4, 3, 0, 0); wait_done(300, 0);
    chk("a_words", obs_q.size(), 30);
    chk("a_span", fe_cyc - fs_cyc, 29);
    chk("a_hdr_cols", obs_q[2 + `Image_num_cols].val, 4);
    chk("a_hdr_rows", obs_q[2 + `Image_num_rows].val, 3);
    chk("a_hdr_fcnt", obs_q[2 + HL - 1].val, 0);
    for (int c = 0; c < 4; c++) chk("a_row2_pix", obs_q[24 + c].val, 2 + c);

    // checker, second frame
    issue(4, 3, 0, 2); wait_done(300, 0);
    chk("b_hdr_fcnt", obs_q[2 + HL - 1].val, 1);
    for (int c = 0; c < 4; c++) chk("b_row1_pix", obs_q[18 + c].val, (c % 2 == 0) ? PMAX : 0);

    // 3-cycle stall inside row 1
    issue(4, 3, 0, 0); wait_rs(2);
    @(posedge clk); #1 stall = 1'b1;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    wait_done(300, 0);
    chk("s_words", obs_q.size(), 30);
    chk("s_span", fe_cyc - fs_cyc, 32);

    // row gap
    issue(2, 2, 3, 1); wait_done(300, 0);
    chk("g_words", obs_q.size(), 20);
    chk("g_span", fe_cyc - fs_cyc, 25);

    // zero rows, then zero cols
    issue(5, 0, 2, 0); wait_done(300, 0);
    chk("r0_words", obs_q.size(), 12);
    chk("r0_hend", obs_q[10].dt, `DTYPE_HEADER_END);
    chk("r0_fend", obs_q[11].dt, `DTYPE_FRAME_END);
    issue(0, 2, 0, 0); wait_done(300, 0);
    chk("c0_words", obs_q.size(), 16);
    chk("c0_rs", obs_q[11].dt, `DTYPE_ROW_START);
    chk("c0_re", obs_q[12].dt, `DTYPE_ROW_END);

    // randomized frames with random stalls
    for (int i = 0; i < 12; i++) begin
      issue($urandom_range(0, 6), $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 3));
      wait_done(3000, 1);
    end

    // enable dropped during header; starts while busy ignored
    issue(4, 3, 0, 1);
    n = 0;
    while (obs_q.size() < 4 && n < 100) begin @(negedge clk); n++; end
    #1 enable = 1'b0;
    repeat (2) begin @(posedge clk); #1 start = 1'b1; @(posedge clk); #1 start = 1'b0; end
    wait_done(300, 0);
    chk("en_words", obs_q.size(), 30);
    chk("en_last_fend", obs_q[obs_q.size() - 1].dt, `DTYPE_FRAME_END);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 chk("en_low_busy", busy, 0);
    enable = 1'b1;

    // back-to-back frames with start held high
    num_cols = 3; num_rows = 1; row_gap = 0; pattern = 0;
    push_frame(3, 1, 0, m_fcnt); push_frame(3, 1, 0, m_fcnt + 1); m_fcnt += 2;
    base = fs_total;
    @(posedge clk); #1 start = 1'b1;
    n = 0;
    while (fs_total < base + 2 && n < 200) begin @(negedge clk); n++; end
    start = 1'b0;
    if (n >= 200) chk("timeout_b2b", fs_total - base, 2);
    wait_done(300, 0);
    chk("b2b_fe_to_fs", fe_to_fs, 2);

    // reset mid-row abandons the frame and clears the frame counter
    fe_before = fe_cyc;
    issue(4, 3, 0, 0); wait_rs(1);
    @(posedge clk); #1 resetb = 1'b0;
    exp_q.delete(); m_fcnt = 0;
    @(negedge clk);
    chk("mr_dvo", dvo, 0); chk("mr_busy", busy, 0); chk("mr_dtypeo", dtypeo, 0);
    repeat (2) @(posedge clk);
    #1 resetb = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("pr_dvo", dvo, 0); chk("pr_busy", busy, 0);
    chk("mr_no_fend", fe_cyc, fe_before);
    issue(4, 3, 0, 3); wait_done(300, 0);
    chk("pr_words", obs_q.size(), 30);
    chk("pr_hdr_fcnt", obs_q[2 + HL - 1].val, 0);
    chk("pr_pix_fcnt", obs_q[12].val, 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end
endmodule
